// File: rtl/xlate_pkg.sv
// Shared types and constants for the data-side address translation unit.
package xlate_pkg;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] PS_4MB     = 6'd21;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} xlate_state_e;

  // 4MB pages are held as the 4KB slice that was actually touched.
  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic [9:0]  asid;
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
  } utlb_entry_t;
endpackage

// File: rtl/utlb_array.sv
// Fully-associative micro-TLB: CAM match, round-robin fill, bulk invalidate.
module utlb_array import xlate_pkg::*; #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] vpn,
  input  logic [9:0]  asid,
  output logic        hit,
  output logic [19:0] hit_ppn,
  output logic [1:0]  hit_plv,
  output logic [1:0]  hit_mat,
  output logic        hit_d,
  input  logic        fill,
  input  logic [19:0] fill_vpn,
  input  logic [9:0]  fill_asid,
  input  logic [19:0] fill_ppn,
  input  logic [1:0]  fill_plv,
  input  logic [1:0]  fill_mat,
  input  logic        fill_d,
  input  logic        inv
);
  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  utlb_entry_t [ENTRIES-1:0] ent;
  logic [ENTRIES-1:0]        match;
  logic [PTR_W-1:0]          rr;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cam
    assign match[gi] = ent[gi].valid && ent[gi].vpn == vpn && ent[gi].asid == asid;
  end

  // Entries never duplicate (fill only follows a miss), so an OR-mux suffices.
  always_comb begin
    hit     = |match;
    hit_ppn = '0;
    hit_plv = '0;
    hit_mat = '0;
    hit_d   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) begin
        hit_ppn = hit_ppn | ent[i].ppn;
        hit_plv = hit_plv | ent[i].plv;
        hit_mat = hit_mat | ent[i].mat;
        hit_d   = hit_d   | ent[i].d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent <= '0;
      rr  <= '0;
    end else if (inv) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
    end else if (fill) begin
      ent[rr] <= '{valid: 1'b1, vpn: fill_vpn, asid: fill_asid, ppn: fill_ppn,
                   plv: fill_plv, mat: fill_mat, d: fill_d};
      rr      <= (rr == PTR_W'(ENTRIES-1)) ? '0 : rr + 1'b1;
    end
  end
endmodule

// File: rtl/data_addr_xlate.sv
// EX-stage data address translation: ALE, direct mode, DMW, uTLB, main-TLB lookup.
module data_addr_xlate import xlate_pkg::*; #(
  parameter int UTLB_ENTRIES = 4,
  parameter int DMW_NUM      = 2,
  parameter int TLB_IDX_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   utlb_inv,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_va,
  input  logic                   req_wr,
  input  logic [1:0]             req_size,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_pa,
  output logic [1:0]             rsp_mat,
  output logic                   rsp_excep,
  output logic [5:0]             rsp_ecode,
  output logic [31:0]            rsp_badv,
  output logic                   tlb_req,
  output logic [18:0]            tlb_vppn,
  output logic                   tlb_va_bit12,
  output logic [9:0]             tlb_asid,
  input  logic                   tlb_found,
  input  logic                   tlb_v,
  input  logic                   tlb_d,
  input  logic [TLB_IDX_W-1:0]   tlb_index,
  input  logic [19:0]            tlb_ppn,
  input  logic [5:0]             tlb_ps,
  input  logic [1:0]             tlb_plv,
  input  logic [1:0]             tlb_mat,
  input  logic                   csr_crmd_pg,
  input  logic [1:0]             csr_crmd_plv,
  input  logic [1:0]             csr_crmd_datm,
  input  logic [9:0]             csr_asid,
  input  logic [DMW_NUM-1:0]     csr_dmw_plv_met,
  input  logic [3*DMW_NUM-1:0]   csr_dmw_vseg,
  input  logic [3*DMW_NUM-1:0]   csr_dmw_pseg,
  input  logic [2*DMW_NUM-1:0]   csr_dmw_mat
);
  xlate_state_e state, state_nxt;
  logic [31:0] va_q;
  logic        wr_q;
  logic        accept, ale, dmw_hit, go_lookup, load_rsp;
  logic [31:0] dmw_pa, pg_va, res_pa;
  logic [1:0]  dmw_mat, res_mat;
  logic        u_hit, u_d, pg_found, pg_v, pg_d, pg_wr, pg_excep, res_excep;
  logic [19:0] u_ppn, pg_ppn;
  logic [1:0]  u_plv, u_mat, pg_plv, pg_mat;
  logic [5:0]  pg_ecode, res_ecode;
  logic        unused_dbg;

  assign unused_dbg   = ^tlb_index;
  assign req_ready    = (state == S_IDLE);
  assign rsp_valid    = (state == S_RESP);
  assign tlb_req      = (state == S_LOOKUP);
  assign tlb_vppn     = va_q[31:13];
  assign tlb_va_bit12 = va_q[12];
  assign tlb_asid     = csr_asid;
  assign accept       = req_valid && req_ready;
  assign ale          = (req_size == 2'd1 && req_va[0]) || (req_size == 2'd2 && req_va[1:0] != 2'b00);

  // Descending scan so the lowest-index matching window wins.
  always_comb begin
    dmw_hit = 1'b0;
    dmw_pa  = '0;
    dmw_mat = '0;
    for (int i = DMW_NUM-1; i >= 0; i--) begin
      if (csr_dmw_plv_met[i] && csr_dmw_vseg[3*i +: 3] == req_va[31:29]) begin
        dmw_hit = 1'b1;
        dmw_pa  = {csr_dmw_pseg[3*i +: 3], req_va[28:0]};
        dmw_mat = csr_dmw_mat[2*i +: 2];
      end
    end
  end

  utlb_array #(.ENTRIES(UTLB_ENTRIES)) u_utlb (
    .clk(clk), .reset(reset), .vpn(req_va[31:12]), .asid(csr_asid),
    .hit(u_hit), .hit_ppn(u_ppn), .hit_plv(u_plv), .hit_mat(u_mat), .hit_d(u_d),
    .fill(tlb_req && tlb_found && tlb_v && !flush),
    .fill_vpn(va_q[31:12]), .fill_asid(csr_asid), .fill_ppn(pg_ppn),
    .fill_plv(tlb_plv), .fill_mat(tlb_mat), .fill_d(tlb_d), .inv(utlb_inv)
  );

  // Page checks share one path: uTLB hit at accept, main-TLB result in LOOKUP.
  always_comb begin
    pg_va    = tlb_req ? va_q : req_va;
    pg_wr    = tlb_req ? wr_q : req_wr;
    pg_found = tlb_req ? tlb_found : 1'b1;
    pg_v     = tlb_req ? tlb_v : 1'b1;
    pg_d     = tlb_req ? tlb_d : u_d;
    pg_plv   = tlb_req ? tlb_plv : u_plv;
    pg_mat   = tlb_req ? tlb_mat : u_mat;
    pg_ppn   = u_ppn;
    if (tlb_req) pg_ppn = (tlb_ps == PS_4MB) ? {tlb_ppn[19:9], va_q[20:12]} : tlb_ppn;
    pg_excep = 1'b1;
    pg_ecode = 6'd0;
    if (!pg_found)                   pg_ecode = ECODE_TLBR;
    else if (!pg_v)                  pg_ecode = pg_wr ? ECODE_PIS : ECODE_PIL;
    else if (csr_crmd_plv > pg_plv)  pg_ecode = ECODE_PPI;
    else if (pg_wr && !pg_d)         pg_ecode = ECODE_PME;
    else                             pg_excep = 1'b0;
  end

  always_comb begin
    res_pa    = {pg_ppn, pg_va[11:0]};
    res_mat   = pg_mat;
    res_excep = pg_excep;
    res_ecode = pg_ecode;
    if (!tlb_req) begin
      if (ale) begin
        res_pa = req_va; res_mat = 2'd0; res_excep = 1'b1; res_ecode = ECODE_ALE;
      end else if (!csr_crmd_pg) begin
        res_pa = req_va; res_mat = csr_crmd_datm; res_excep = 1'b0; res_ecode = 6'd0;
      end else if (dmw_hit) begin
        res_pa = dmw_pa; res_mat = dmw_mat; res_excep = 1'b0; res_ecode = 6'd0;
      end
    end
  end

  assign go_lookup = csr_crmd_pg && !ale && !dmw_hit && !u_hit;
  assign load_rsp  = (accept && !go_lookup) || tlb_req;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = go_lookup ? S_LOOKUP : S_RESP;
      S_LOOKUP: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      va_q      <= '0;
      wr_q      <= 1'b0;
      rsp_pa    <= '0;
      rsp_mat   <= '0;
      rsp_excep <= 1'b0;
      rsp_ecode <= '0;
      rsp_badv  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        va_q <= req_va;
        wr_q <= req_wr;
      end
      if (load_rsp) begin
        rsp_pa    <= res_pa;
        rsp_mat   <= res_mat;
        rsp_excep <= res_excep;
        rsp_ecode <= res_ecode;
        rsp_badv  <= pg_va;
      end
    end
  end
endmodule

// File: tb/tb_data_addr_xlate.sv
// Randomized + directed bench for data_addr_xlate against an arithmetic reference model.
module tb_data_addr_xlate;
  localparam int UE = 4;
  localparam int DN = 2;
  localparam int IW = 4;

  logic clk = 0, reset = 1, flush = 0, utlb_inv = 0;
  logic req_valid = 0, req_wr = 0, rsp_ready = 0;
  logic [31:0] req_va = 0;
  logic [1:0]  req_size = 0;
  logic req_ready, rsp_valid, rsp_excep, tlb_req, tlb_va_bit12;
  logic [31:0] rsp_pa, rsp_badv;
  logic [1:0]  rsp_mat;
  logic [5:0]  rsp_ecode;
  logic [18:0] tlb_vppn;
  logic [9:0]  tlb_asid;
  logic t_found = 0, t_v = 0, t_d = 0;
  logic [19:0] t_ppn = 0;
  logic [5:0]  t_ps = 12;
  logic [1:0]  t_plv = 0, t_mat = 0;
  logic [IW-1:0] t_idx = 0;
  logic pg = 0;
  logic [1:0] cplv = 0, datm = 0;
  logic [9:0] asid = 0;
  logic [DN-1:0]   plv_met = 0;
  logic [3*DN-1:0] vseg = 0, pseg = 0;
  logic [2*DN-1:0] dmat = 0;

  int n_assert = 0, n_fail = 0;

  // Reference uTLB: what pages are cached and where the next fill lands.
  bit          m_val[UE];
  logic [19:0] m_vpn[UE], m_ppn[UE];
  logic [9:0]  m_asid[UE];
  logic [1:0]  m_plv[UE], m_mat[UE];
  logic        m_d[UE];
  int          m_ptr = 0;

  always #5 clk = ~clk;

  data_addr_xlate #(.UTLB_ENTRIES(UE), .DMW_NUM(DN), .TLB_IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .utlb_inv(utlb_inv),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_wr(req_wr),
    .req_size(req_size), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pa(rsp_pa),
    .rsp_mat(rsp_mat), .rsp_excep(rsp_excep), .rsp_ecode(rsp_ecode), .rsp_badv(rsp_badv),
    .tlb_req(tlb_req), .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12), .tlb_asid(tlb_asid),
    .tlb_found(t_found), .tlb_v(t_v), .tlb_d(t_d), .tlb_index(t_idx), .tlb_ppn(t_ppn),
    .tlb_ps(t_ps), .tlb_plv(t_plv), .tlb_mat(t_mat), .csr_crmd_pg(pg), .csr_crmd_plv(cplv),
    .csr_crmd_datm(datm), .csr_asid(asid), .csr_dmw_plv_met(plv_met), .csr_dmw_vseg(vseg),
    .csr_dmw_pseg(pseg), .csr_dmw_mat(dmat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] fault(input logic found, v, d, wr, input logic [1:0] plv);
    if (!found) return 6'h3F;
    if (!v) return wr ? 6'h02 : 6'h01;
    if (cplv > plv) return 6'h07;
    if (wr && !d) return 6'h04;
    return 6'h00;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < UE; i++) m_val[i] = 0;
  endfunction

  task automatic inv_pulse();
    @(negedge clk); utlb_inv = 1;
    @(negedge clk); utlb_inv = 0;
    model_clear();
  endtask

  // inj: 0 none, 1 flush during LOOKUP, 2 utlb_inv during LOOKUP
  task automatic do_req(input logic [31:0] va, input logic wr, input logic [1:0] size, input int inj);
    logic [5:0] e_ec;
    logic [31:0] e_pa, p32;
    logic [1:0] e_mat;
    logic e_lk;
    int hit_i, dw, lat;
    logic seen;
    e_lk = 0; e_ec = 0; e_pa = 0; e_mat = 0;
    p32 = {12'd0, t_ppn};
    if ((size == 2'd1 && va[0]) || (size == 2'd2 && va[1:0] != 2'b00)) e_ec = 6'h09;
    else if (!pg) begin e_pa = va; e_mat = datm; end
    else begin
      dw = -1;
      for (int i = DN-1; i >= 0; i--) if (plv_met[i] && vseg[3*i +: 3] == va[31:29]) dw = i;
      hit_i = -1;
      for (int i = 0; i < UE; i++)
        if (m_val[i] && m_vpn[i] == va[31:12] && m_asid[i] == asid) hit_i = i;
      if (dw >= 0) begin
        e_pa = (32'(pseg[3*dw +: 3]) << 29) | (va & 32'h1FFF_FFFF);
        e_mat = dmat[2*dw +: 2];
      end else if (hit_i >= 0) begin
        e_ec = fault(1'b1, 1'b1, m_d[hit_i], wr, m_plv[hit_i]);
        e_pa = (32'(m_ppn[hit_i]) << 12) | (va & 32'hFFF);
        e_mat = m_mat[hit_i];
      end else begin
        e_lk = 1;
        e_ec = fault(t_found, t_v, t_d, wr, t_plv);
        e_pa = (t_ps == 6'd21) ? (((p32 >> 9) << 21) | (va & 32'h1F_FFFF)) : ((p32 << 12) | (va & 32'hFFF));
        e_mat = t_mat;
      end
    end
    @(negedge clk);
    req_valid = 1; req_va = va; req_wr = wr; req_size = size;
    @(posedge clk); #1;
    req_valid = 0; seen = 0; lat = 1;
    if (inj != 0 && e_lk) begin
      seen = tlb_req;
      if (inj == 1) flush = 1; else utlb_inv = 1;
      @(posedge clk); #1;
      flush = 0; utlb_inv = 0;
      model_clear_if(inj == 2);
      if (inj == 1) begin
        check("flush_saw_lookup", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 3; k++) begin
          check("flush_no_rsp", {31'd0, rsp_valid}, 32'd0);
          check("flush_ready", {31'd0, req_ready}, 32'd1);
          @(posedge clk); #1;
        end
        return;
      end
      lat = 2;
    end
    while (!rsp_valid && lat < 8) begin
      if (tlb_req) seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    check("latency", 32'(lat), e_lk ? 32'd2 : 32'd1);
    check("tlb_req_seen", {31'd0, seen}, {31'd0, e_lk});
    check("excep", {31'd0, rsp_excep}, {31'd0, (e_ec != 0)});
    if (e_ec != 0) check("ecode", {26'd0, rsp_ecode}, {26'd0, e_ec});
    else begin
      check("pa", rsp_pa, e_pa);
      check("mat", {30'd0, rsp_mat}, {30'd0, e_mat});
    end
    check("badv", rsp_badv, va);
    @(posedge clk); #1;
    check("hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("hold_badv", rsp_badv, va);
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
    check("back_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    if (e_lk && inj == 0 && t_found && t_v) begin
      m_val[m_ptr] = 1; m_vpn[m_ptr] = va[31:12]; m_asid[m_ptr] = asid;
      m_ppn[m_ptr] = (t_ps == 6'd21) ? ((t_ppn >> 9) << 9) | 20'(va[20:12]) : t_ppn;
      m_plv[m_ptr] = t_plv; m_mat[m_ptr] = t_mat; m_d[m_ptr] = t_d;
      m_ptr = (m_ptr + 1) % UE;
    end
  endtask

  function automatic void model_clear_if(input bit c);
    if (c) model_clear();
  endfunction

  task automatic set_tlb(input logic f, v, d, input logic [19:0] ppn, input logic [5:0] ps,
                         input logic [1:0] plv, mat);
    t_found = f; t_v = v; t_d = d; t_ppn = ppn; t_ps = ps; t_plv = plv; t_mat = mat;
  endtask

  initial begin
    model_clear();
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_tlb_req", {31'd0, tlb_req}, 32'd0);
    check("rst_pa", rsp_pa, 32'd0);
    check("rst_excep", {26'd0, rsp_excep, rsp_ecode}, 32'd0);
    @(negedge clk); reset = 0;

    // direct mode
    pg = 0; datm = 2'd1;
    do_req(32'h1C00_0004, 0, 2'd2, 0);
    // DMW window 1
    pg = 1; plv_met = 2'b10; vseg = {3'd5, 3'd0}; pseg = {3'd0, 3'd7}; dmat = {2'd1, 2'd2};
    do_req(32'hA000_1000, 0, 2'd2, 0);
    // both windows match: lowest index wins
    plv_met = 2'b11; vseg = {3'd5, 3'd5}; pseg = {3'd2, 3'd1};
    do_req(32'hA000_2000, 1, 2'd0, 0);
    plv_met = 2'b00;
    // miss then uTLB hit (main TLB made unusable to prove caching)
    set_tlb(1, 1, 1, 20'h12345, 6'd12, 2'd0, 2'd1);
    do_req(32'h0040_2ABC, 0, 2'd2, 0);
    set_tlb(0, 0, 0, 20'h0, 6'd12, 2'd0, 2'd0);
    do_req(32'h0040_2ABC, 0, 2'd2, 0);
    // faults
    set_tlb(1, 1, 0, 20'h00111, 6'd12, 2'd0, 2'd1);
    do_req(32'h0050_0000, 1, 2'd2, 0);
    do_req(32'h0050_0008, 1, 2'd2, 0);
    set_tlb(0, 0, 0, 20'h0, 6'd12, 2'd0, 2'd0);
    do_req(32'h0060_0000, 0, 2'd2, 0);
    do_req(32'h0070_0001, 0, 2'd1, 0);
    set_tlb(1, 0, 1, 20'h00222, 6'd12, 2'd0, 2'd0);
    do_req(32'h0071_0000, 1, 2'd0, 0);
    cplv = 2'd3; set_tlb(1, 1, 1, 20'h00333, 6'd12, 2'd0, 2'd0);
    do_req(32'h0072_0000, 0, 2'd0, 0);
    cplv = 2'd0;
    // 4MB page
    set_tlb(1, 1, 1, 20'hABCDE, 6'd21, 2'd0, 2'd1);
    do_req(32'h0081_2345, 0, 2'd0, 0);
    check("pa_4mb_abs", rsp_pa, 32'hABC1_2345);
    // round-robin eviction
    inv_pulse();
    for (int i = 0; i <= UE; i++) begin
      set_tlb(1, 1, 1, 20'h40000 + 20'(i), 6'd12, 2'd0, 2'd0);
      do_req(32'h0100_0000 + (i << 12), 0, 2'd2, 0);
    end
    set_tlb(1, 1, 1, 20'h50000, 6'd12, 2'd0, 2'd0);
    do_req(32'h0100_0000, 0, 2'd2, 0);
    do_req(32'h0100_2000, 0, 2'd2, 0);
    // flush / utlb_inv during LOOKUP
    do_req(32'h0200_0000, 0, 2'd2, 1);
    do_req(32'h0200_0000, 0, 2'd2, 0);
    do_req(32'h0300_0000, 0, 2'd2, 2);
    do_req(32'h0200_0000, 0, 2'd2, 0);
    // reset while in LOOKUP
    @(negedge clk); req_valid = 1; req_va = 32'h0400_0000; req_wr = 0; req_size = 2'd2;
    @(posedge clk); #1; req_valid = 0;
    check("mid_lookup", {31'd0, tlb_req}, 32'd1);
    reset = 1; #1;
    check("mid_rst_state", {29'd0, tlb_req, rsp_valid, req_ready}, 32'd1);
    check("mid_rst_pa", rsp_pa, 32'd0);
    @(negedge clk); reset = 0;
    model_clear(); m_ptr = 0;
    do_req(32'h0200_0000, 0, 2'd2, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] va;
      int inj;
      pg = ($urandom_range(0, 9) != 0);
      datm = 2'($urandom_range(0, 3));
      plv_met = 2'($urandom_range(0, 3));
      vseg = {($urandom_range(0, 1) != 0) ? 3'd5 : 3'd4, 3'd4};
      pseg = 6'($urandom); dmat = 4'($urandom);
      cplv = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
      asid = 10'($urandom_range(0, 1));
      set_tlb($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
              20'($urandom), ($urandom_range(0, 3) == 0) ? 6'd21 : 6'd12,
              2'($urandom), 2'($urandom));
      t_idx = 4'($urandom);
      va = {3'($urandom_range(0, 7)), 8'd0, 9'($urandom_range(0, 3)), 12'($urandom)};
      inj = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
      if ($urandom_range(0, 49) == 0) inv_pulse();
      do_req(va, 1'($urandom), 2'($urandom_range(0, 2)), inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
